ram_port_arbiter: RTL and testbench

- Shares one RAM request port (toward the UMA/SDRAM path) among NUM_PORTS requesters, e.g. the MSX bus slot logic, the boot/flash loader and the TF DMA.
- Uses round-robin arbitration. Port 0 can optionally get priority, bounded by a starvation limit.
- Allows one outstanding transaction at a time. Request fields are latched at grant, and read data and acks are routed back to the owner.
- Runs entirely in the CLK_BASE (108 MHz) domain.

---
 rtl/ram_arb_pkg.sv | 33 +++
 rtl/ram_arb_select.sv | 39 +++
 rtl/ram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter: FSM state encoding,
// wait-counter width and the round-robin search used by the winner selector.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2
   } arb_state_t;

   localparam int WAIT_CNT_WIDTH = 8;
   localparam int MAX_PORTS      = 8;

   // First set bit of req_mask strictly after ptr, wrapping modulo num_ports.
   function automatic logic [2:0] rr_pick(input logic [MAX_PORTS-1:0] req_mask,
                                          input logic [2:0]           ptr,
                                          input int                   num_ports);
      logic [2:0] pick;
      logic [2:0] idx;
      logic       found;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= MAX_PORTS; k++) begin
         idx = 3'((int'(ptr) + k) % num_ports);
         if (k <= num_ports && !found && req_mask[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/ram_arb_select.sv
// Combinational winner selection: starving ports first (round-robin), then
// optional port-0 priority, then plain round-robin after rr_ptr.
module ram_arb_select
   import ram_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 3,
   parameter int PRIO_PORT0 = 1,
   parameter int MAX_WAIT   = 8
) (
   input  logic [NUM_PORTS-1:0]                req,
   input  logic [NUM_PORTS*WAIT_CNT_WIDTH-1:0] wait_cnt,
   input  logic [$clog2(NUM_PORTS)-1:0]        rr_ptr,
   output logic [$clog2(NUM_PORTS)-1:0]        winner
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT_C = WAIT_CNT_WIDTH'(MAX_WAIT);

   logic [MAX_PORTS-1:0] req_ext;
   logic [MAX_PORTS-1:0] starve_ext;

   always_comb begin
      req_ext    = '0;
      starve_ext = '0;
      req_ext[NUM_PORTS-1:0] = req;
      for (int i = 0; i < NUM_PORTS; i++) begin
         starve_ext[i] = req[i] && (wait_cnt[i*WAIT_CNT_WIDTH +: WAIT_CNT_WIDTH] >= MAX_WAIT_C);
      end
      winner = '0;
      if (|starve_ext) begin
         winner = PW'(rr_pick(starve_ext, 3'(rr_ptr), NUM_PORTS));
      end else if ((PRIO_PORT0 != 0) && req[0]) begin
         winner = '0;
      end else begin
         winner = PW'(rr_pick(req_ext, 3'(rr_ptr), NUM_PORTS));
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one downstream RAM command port among NUM_PORTS requesters with one
// transaction in flight; request fields are latched at grant, acks/data routed to the owner.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 3,
   parameter int ADDR_WIDTH = 23,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH/8,
   parameter int PRIO_PORT0 = 1,
   parameter int MAX_WAIT   = 8
) (
   input  logic                             CLK_BASE,
   input  logic                             RESET_n,
   input  logic [NUM_PORTS-1:0]             REQ,
   input  logic [NUM_PORTS-1:0]             REQ_WE,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  REQ_ADDR,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  REQ_WDATA,
   input  logic [NUM_PORTS*BE_WIDTH-1:0]    REQ_BE,
   output logic [NUM_PORTS-1:0]             REQ_ACK,
   output logic [NUM_PORTS-1:0]             RD_VALID,
   output logic [DATA_WIDTH-1:0]            RDATA,
   output logic                             M_REQ,
   output logic                             M_WE,
   output logic [ADDR_WIDTH-1:0]            M_ADDR,
   output logic [DATA_WIDTH-1:0]            M_WDATA,
   output logic [BE_WIDTH-1:0]              M_BE,
   input  logic                             M_ACK,
   input  logic                             M_RVALID,
   input  logic [DATA_WIDTH-1:0]            M_RDATA,
   output logic                             BUSY,
   output logic [$clog2(NUM_PORTS)-1:0]     OWNER
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam logic [PW-1:0] RR_RESET = PW'(NUM_PORTS-1);
   localparam int WC = WAIT_CNT_WIDTH;

   arb_state_t                 state;
   arb_state_t                 state_nxt;
   logic [PW-1:0]              rr_ptr;
   logic [PW-1:0]              winner;
   logic [NUM_PORTS*WC-1:0]    wait_cnt;
   logic [NUM_PORTS-1:0]       req_elig;
   logic                       grant;

   // The port being acked this cycle still shows its old REQ level; hide it.
   assign req_elig = REQ & ~REQ_ACK;
   assign grant    = (state == IDLE) && (|req_elig);
   assign BUSY     = (state != IDLE);

   ram_arb_select #(
      .NUM_PORTS  (NUM_PORTS),
      .PRIO_PORT0 (PRIO_PORT0),
      .MAX_WAIT   (MAX_WAIT)
   ) u_select (
      .req      (req_elig),
      .wait_cnt (wait_cnt),
      .rr_ptr   (rr_ptr),
      .winner   (winner)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant)    state_nxt = ISSUE;
         ISSUE:   if (M_ACK)    state_nxt = M_WE ? IDLE : RDWAIT;
         RDWAIT:  if (M_RVALID) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_BASE or negedge RESET_n) begin
      if (!RESET_n) begin
         state    <= IDLE;
         M_REQ    <= 1'b0;
         M_WE     <= 1'b0;
         M_ADDR   <= '0;
         M_WDATA  <= '0;
         M_BE     <= '0;
         OWNER    <= '0;
         rr_ptr   <= RR_RESET;
         wait_cnt <= '0;
         REQ_ACK  <= '0;
         RD_VALID <= '0;
         RDATA    <= '0;
      end else begin
         state    <= state_nxt;
         REQ_ACK  <= '0;
         RD_VALID <= '0;
         case (state)
            IDLE: begin
               if (grant) begin
                  M_REQ   <= 1'b1;
                  M_WE    <= REQ_WE[winner];
                  M_ADDR  <= REQ_ADDR[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                  M_WDATA <= REQ_WDATA[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                  M_BE    <= REQ_BE[int'(winner)*BE_WIDTH +: BE_WIDTH];
                  OWNER   <= winner;
                  rr_ptr  <= winner;
                  for (int i = 0; i < NUM_PORTS; i++) begin
                     if (i == int'(winner)) begin
                        wait_cnt[i*WC +: WC] <= '0;
                     end else if (req_elig[i] && (wait_cnt[i*WC +: WC] != {WC{1'b1}})) begin
                        wait_cnt[i*WC +: WC] <= wait_cnt[i*WC +: WC] + 1'b1;
                     end
                  end
               end
            end
            ISSUE: begin
               if (M_ACK) begin
                  M_REQ          <= 1'b0;
                  REQ_ACK[OWNER] <= 1'b1;
               end
            end
            RDWAIT: begin
               if (M_RVALID) begin
                  RDATA           <= M_RDATA;
                  RD_VALID[OWNER] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_ram_port_arbiter;

   localparam int NP = 3;
   localparam int AW = 23;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int MW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NP-1:0]    req, f_we, req_ack, rd_valid;
   logic [AW-1:0]    f_addr [NP];
   logic [DW-1:0]    f_wdata [NP];
   logic [BW-1:0]    f_be [NP];
   logic [NP*AW-1:0] req_addr;
   logic [NP*DW-1:0] req_wdata;
   logic [NP*BW-1:0] req_be;
   logic [DW-1:0]    rdata, m_wdata, m_rdata;
   logic [AW-1:0]    m_addr;
   logic [BW-1:0]    m_be;
   logic             m_req, m_we, m_ack, m_rvalid, busy;
   logic [1:0]       owner;

   for (genvar g = 0; g < NP; g++) begin : g_pack
      assign req_addr[g*AW +: AW]  = f_addr[g];
      assign req_wdata[g*DW +: DW] = f_wdata[g];
      assign req_be[g*BW +: BW]    = f_be[g];
   end

   ram_port_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
      .PRIO_PORT0(1), .MAX_WAIT(MW)
   ) dut (
      .CLK_BASE(clk), .RESET_n(rst_n), .REQ(req), .REQ_WE(f_we),
      .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_BE(req_be),
      .REQ_ACK(req_ack), .RD_VALID(rd_valid), .RDATA(rdata),
      .M_REQ(m_req), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_BE(m_be),
      .M_ACK(m_ack), .M_RVALID(m_rvalid), .M_RDATA(m_rdata),
      .BUSY(busy), .OWNER(owner)
   );

   // Second instance: pure round-robin, downstream always accepting writes.
   logic [NP-1:0]    rr_req;
   logic [NP-1:0]    rr_ack_o, rr_rdv_o;
   logic [DW-1:0]    rr_rdata_o, rr_mwdata_o;
   logic [AW-1:0]    rr_maddr_o;
   logic [BW-1:0]    rr_mbe_o;
   logic             rr_mreq, rr_mwe_o, rr_busy_o, rr_mreq_q;
   logic [1:0]       rr_owner;
   logic [1:0]       rr_obs_q [$];

   ram_port_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
      .PRIO_PORT0(0), .MAX_WAIT(8)
   ) dut_rr (
      .CLK_BASE(clk), .RESET_n(rst_n), .REQ(rr_req), .REQ_WE({NP{1'b1}}),
      .REQ_ADDR({NP*AW{1'b0}}), .REQ_WDATA({NP*DW{1'b0}}), .REQ_BE({NP*BW{1'b1}}),
      .REQ_ACK(rr_ack_o), .RD_VALID(rr_rdv_o), .RDATA(rr_rdata_o),
      .M_REQ(rr_mreq), .M_WE(rr_mwe_o), .M_ADDR(rr_maddr_o), .M_WDATA(rr_mwdata_o), .M_BE(rr_mbe_o),
      .M_ACK(1'b1), .M_RVALID(1'b0), .M_RDATA({DW{1'b0}}),
      .BUSY(rr_busy_o), .OWNER(rr_owner)
   );

   initial rr_mreq_q = 1'b0;
   always @(negedge clk) begin
      if (rr_mreq && !rr_mreq_q) rr_obs_q.push_back(rr_owner);
      rr_mreq_q = rr_mreq;
   end

   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: phase 0=idle 1=command outstanding 2=awaiting read data.
   int            md_phase, md_owner, md_rr;
   int            md_wait [NP];
   logic [NP-1:0] md_ack;
   logic          md_we;
   logic [AW-1:0] md_addr;
   logic [DW-1:0] md_wdata, md_rdata;
   logic [BW-1:0] md_be;

   logic [1:0]    obs_q [$];
   int            ack_pulses [NP];
   int            rdv_pulses [NP];
   logic          m_req_q;
   logic          cap_we;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_wdata;
   logic [BW-1:0] cap_be;

   // Downstream responder
   logic          rsp_auto, rsp_random;
   int            rsp_phase, rsp_cnt, ack_dly, rv_dly;
   logic [DW-1:0] rsp_rdata;

   task automatic model_reset();
      md_phase = 0; md_owner = 0; md_rr = NP-1;
      for (int p = 0; p < NP; p++) md_wait[p] = 0;
      md_ack = '0; md_rdata = '0;
      m_req_q = 1'b0;
      rsp_phase = -1;
   endtask

   task automatic clear_pulses();
      for (int p = 0; p < NP; p++) begin ack_pulses[p] = 0; rdv_pulses[p] = 0; end
   endtask

   function automatic int model_pick(input logic [NP-1:0] elig);
      int order [$];
      for (int k = 1; k <= NP; k++) order.push_back((md_rr + k) % NP);
      foreach (order[j]) if (elig[order[j]] && md_wait[order[j]] >= MW) return order[j];
      if (elig[0]) return 0;
      foreach (order[j]) if (elig[order[j]]) return order[j];
      return -1;
   endfunction

   task automatic model_step();
      logic [NP-1:0] elig, nack, nrdv;
      int w;
      nack = '0;
      nrdv = '0;
      if (!rst_n) begin
         model_reset();
      end else begin
         case (md_phase)
            0: begin
               elig = req & ~md_ack;
               if (elig != '0) begin
                  w = model_pick(elig);
                  for (int p = 0; p < NP; p++) begin
                     if (p == w) md_wait[p] = 0;
                     else if (elig[p] && md_wait[p] < 255) md_wait[p]++;
                  end
                  md_owner = w; md_rr = w;
                  md_we = f_we[w]; md_addr = f_addr[w]; md_wdata = f_wdata[w]; md_be = f_be[w];
                  md_phase = 1;
               end
            end
            1: if (m_ack) begin nack[md_owner] = 1'b1; md_phase = md_we ? 0 : 2; end
            2: if (m_rvalid) begin nrdv[md_owner] = 1'b1; md_rdata = m_rdata; md_phase = 0; end
            default: md_phase = 0;
         endcase
      end
      md_ack = nack;
      check_eq("req_ack", req_ack, nack);
      check_eq("rd_valid", rd_valid, nrdv);
      check_eq("m_req", m_req, md_phase == 1);
      check_eq("busy", busy, md_phase != 0);
      check_eq("owner", owner, md_owner);
      check_eq("rdata", rdata, md_rdata);
      if (md_phase == 1) begin
         check_eq("m_we", m_we, md_we);
         check_eq("m_addr", m_addr, md_addr);
         check_eq("m_wdata", m_wdata, md_wdata);
         check_eq("m_be", m_be, md_be);
      end
      for (int p = 0; p < NP; p++) begin
         if (req_ack[p]) ack_pulses[p]++;
         if (rd_valid[p]) rdv_pulses[p]++;
      end
      if (m_req && !m_req_q) begin
         obs_q.push_back(owner);
         cap_we = m_we; cap_addr = m_addr; cap_wdata = m_wdata; cap_be = m_be;
      end
      m_req_q = m_req;
   endtask

   task automatic respond();
      if (rsp_auto) begin
         m_ack = 1'b0;
         m_rvalid = 1'b0;
         if (md_phase != rsp_phase) begin
            rsp_phase = md_phase;
            rsp_cnt = 0;
            if (rsp_random) begin ack_dly = $urandom_range(0, 3); rv_dly = $urandom_range(0, 4); end
         end else begin
            rsp_cnt++;
         end
         if (md_phase == 1) m_ack = (rsp_cnt >= ack_dly);
         if (md_phase == 2) begin
            if (rsp_cnt >= rv_dly) begin
               m_rvalid = 1'b1;
               m_rdata = rsp_random ? DW'($urandom) : rsp_rdata;
            end else if (rsp_random && $urandom_range(0, 3) == 0) begin
               m_ack = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_step();
      respond();
   endtask

   task automatic rand_fields(input int p);
      f_we[p] = 1'($urandom_range(0, 1));
      f_addr[p] = AW'($urandom);
      f_wdata[p] = DW'($urandom);
      f_be[p] = BW'($urandom);
   endtask

   task automatic agent_update();
      for (int p = 0; p < NP; p++) begin
         if (!req[p]) begin
            if ($urandom_range(0, 3) == 0) begin rand_fields(p); req[p] = 1'b1; end
         end else if (md_ack[p]) begin
            if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
            else rand_fields(p);
         end else if ($urandom_range(0, 63) == 0) begin
            req[p] = 1'b0;
         end else if ($urandom_range(0, 15) == 0) begin
            rand_fields(p);
         end
      end
   endtask

   int base, p0acks, sum;
   logic [1:0] exp_rr [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
   logic [1:0] exp_st [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};

   initial begin
      req = '0; rr_req = '0;
      for (int p = 0; p < NP; p++) begin f_we[p] = 1'b0; f_addr[p] = '0; f_wdata[p] = '0; f_be[p] = '0; end
      m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      rsp_auto = 1'b1; rsp_random = 1'b0; ack_dly = 0; rv_dly = 0; rsp_rdata = '0; rsp_cnt = 0;
      model_reset();
      clear_pulses();
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Round-robin order on the no-priority instance
      rr_req = 3'b111;
      repeat (14) step();
      rr_req = '0;
      repeat (4) step();
      check_eq("rr_count", rr_obs_q.size() >= 6, 1'b1);
      if (rr_obs_q.size() >= 6)
         for (int k = 0; k < 6; k++) check_eq($sformatf("rr_grant%0d", k), rr_obs_q[k], exp_rr[k]);

      // Single write from port 1, downstream acks 2 cycles after M_REQ
      clear_pulses();
      base = obs_q.size();
      ack_dly = 2;
      f_we[1] = 1'b1; f_addr[1] = 23'h000100; f_wdata[1] = 32'hDEADBEEF; f_be[1] = 4'hF;
      req[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin step(); if (req_ack[1]) req[1] = 1'b0; end
      check_eq("t1_grants", obs_q.size() - base, 1);
      check_eq("t1_owner", obs_q[base], 2'd1);
      check_eq("t1_we", cap_we, 1'b1);
      check_eq("t1_addr", cap_addr, 23'h000100);
      check_eq("t1_wdata", cap_wdata, 32'hDEADBEEF);
      check_eq("t1_be", cap_be, 4'hF);
      check_eq("t1_ack1", ack_pulses[1], 1);
      sum = ack_pulses[0] + ack_pulses[2] + rdv_pulses[0] + rdv_pulses[1] + rdv_pulses[2];
      check_eq("t1_other", sum, 0);
      check_eq("t1_busy", busy, 1'b0);

      // Read routing to port 2, data 5 cycles after M_ACK
      clear_pulses();
      ack_dly = 1; rv_dly = 5; rsp_rdata = 32'h12345678;
      f_we[2] = 1'b0; f_addr[2] = 23'h7FFFFF;
      req[2] = 1'b1;
      for (int i = 0; i < 25; i++) begin step(); if (req_ack[2]) req[2] = 1'b0; end
      check_eq("t2_addr", cap_addr, 23'h7FFFFF);
      check_eq("t2_rdv2", rdv_pulses[2], 1);
      check_eq("t2_rdv_other", rdv_pulses[0] + rdv_pulses[1], 0);
      check_eq("t2_rdata", rdata, 32'h12345678);

      // Starvation override: port 0 reads back-to-back, port 1 waits
      ack_dly = 0; rv_dly = 0;
      base = obs_q.size();
      f_we[0] = 1'b0; f_addr[0] = 23'h000040;
      f_we[1] = 1'b1; f_addr[1] = 23'h000080; f_wdata[1] = 32'h0BADF00D;
      req[0] = 1'b1; req[1] = 1'b1;
      for (int i = 0; i < 200 && obs_q.size() < base + 5; i++) begin
         step();
         if (md_ack[1]) req[1] = 1'b0;
      end
      req = '0;
      repeat (20) step();
      check_eq("t3_count", obs_q.size() >= base + 5, 1'b1);
      if (obs_q.size() >= base + 5)
         for (int k = 0; k < 5; k++) check_eq($sformatf("t3_grant%0d", k), obs_q[base+k], exp_st[k]);

      // Stale-level masking: port 0 keeps REQ through its ack
      base = obs_q.size();
      p0acks = 0;
      f_we[0] = 1'b1; f_we[1] = 1'b1;
      req[0] = 1'b1; req[1] = 1'b1;
      for (int i = 0; i < 60 && req != '0; i++) begin
         step();
         if (md_ack[1]) req[1] = 1'b0;
         if (md_ack[0]) begin p0acks++; if (p0acks == 2) req[0] = 1'b0; end
      end
      req = '0;
      repeat (5) step();
      check_eq("t4_count", obs_q.size() >= base + 3, 1'b1);
      if (obs_q.size() >= base + 3) begin
         check_eq("t4_first", obs_q[base], 2'd0);
         check_eq("t4_second", obs_q[base+1], 2'd1);
         check_eq("t4_third", obs_q[base+2], 2'd0);
      end

      // Reset in the middle of a read
      rv_dly = 10;
      f_we[2] = 1'b0; f_addr[2] = 23'h001234;
      req[2] = 1'b1;
      for (int i = 0; i < 20 && md_phase != 2; i++) begin step(); if (md_ack[2]) req[2] = 1'b0; end
      req[2] = 1'b0;
      check_eq("t5_in_rdwait", md_phase, 2);
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_m_req", m_req, 1'b0);
      check_eq("t5_rst_req_ack", req_ack, 3'b000);
      check_eq("t5_rst_rd_valid", rd_valid, 3'b000);
      check_eq("t5_rst_busy", busy, 1'b0);
      check_eq("t5_rst_owner", owner, 2'd0);
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
      clear_pulses();
      rsp_auto = 1'b0;
      m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
      step();
      m_rvalid = 1'b0;
      rsp_auto = 1'b1;
      repeat (3) step();
      check_eq("t5_late_rdv", rdv_pulses[0] + rdv_pulses[1] + rdv_pulses[2], 0);
      rv_dly = 0;
      f_we[1] = 1'b1; f_addr[1] = 23'h000200; f_wdata[1] = 32'h55AA55AA; f_be[1] = 4'h3;
      req[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin step(); if (req_ack[1]) req[1] = 1'b0; end
      check_eq("t5_after_ack", ack_pulses[1], 1);
      check_eq("t5_after_addr", cap_addr, 23'h000200);

      // Randomized traffic
      base = obs_q.size();
      rsp_random = 1'b1;
      repeat (3000) begin
         step();
         agent_update();
      end
      req = '0;
      repeat (30) step();
      check_eq("t6_progress", obs_q.size() > base + 100, 1'b1);
      check_eq("t6_idle", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
